// File: rtl/rf_pkg.sv
// Shared definitions for the register-file arbiter: register index map,
// data width and the arbiter state encoding.
package rf_pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 5;

   localparam logic [2:0] REG_A = 3'd0;
   localparam logic [2:0] REG_B = 3'd1;
   localparam logic [2:0] REG_C = 3'd2;
   localparam logic [2:0] REG_D = 3'd3;
   localparam logic [2:0] REG_F = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      ACK   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, searching upward with wrap-around.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [PW-1:0]   id_o
);

   always_comb begin
      valid_o = 1'b0;
      id_o    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!valid_o && req_i[(int'(ptr_i) + i) % NREQ]) begin
            valid_o = 1'b1;
            id_o    = PW'((int'(ptr_i) + i) % NREQ);
         end
      end
   end

endmodule

// File: rtl/rf_arb.sv
// Round-robin arbiter/sequencer sharing one register file between NREQ
// requesters; one access per IDLE/DRIVE/ACK sequence, all outputs registered.
module rf_arb
   import rf_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DATA_W,
   parameter int SW   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    wr,
   input  logic [NREQ*SW-1:0] sel,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    ack,
   output logic               err,
   output logic [DW-1:0]      rdata,
   output logic               busy,
   output logic [DW-1:0]      rf_d,
   output logic               rf_as,
   output logic               rf_bs,
   output logic               rf_cs,
   output logic               rf_ds,
   output logic               rf_fs,
   output logic               rf_re,
   output logic               rf_we,
   input  logic [DW-1:0]      rf_p
);

   localparam int PW = $clog2(NREQ);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      id_q, id_d;
   logic               wr_q, wr_d;
   logic [SW-1:0]      sel_q, sel_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [NREQ-1:0]    ack_q, ack_d;
   logic               err_q, err_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic [DW-1:0]      rfd_q, rfd_d;
   logic [4:0]         rfsel_q, rfsel_d;
   logic               re_q, re_d;
   logic               we_q, we_d;

   logic               pickValid;
   logic [PW-1:0]      pickId;
   logic [SW-1:0]      pickSel;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pickValid),
      .id_o    (pickId)
   );

   assign pickSel = sel[int'(pickId)*SW +: SW];

   // The register-file strobes are computed while leaving IDLE so that they
   // are registered outputs during DRIVE and reset can clear them at once.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      wr_d    = wr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      ack_d   = '0;
      err_d   = err_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      rfd_d   = rfd_q;
      rfsel_d = rfsel_q;
      re_d    = re_q;
      we_d    = we_q;
      case (state_q)
         IDLE: begin
            if (pickValid) begin
               id_d    = pickId;
               wr_d    = wr[pickId];
               sel_d   = pickSel;
               wdata_d = wdata[int'(pickId)*DW +: DW];
               busy_d  = 1'b1;
               err_d   = 1'b0;
               state_d = DRIVE;
               if (pickSel < SW'(NUM_REGS)) begin
                  rfsel_d = 5'(1) << pickSel;
                  re_d    = 1'b1;
                  we_d    = wr[pickId];
                  rfd_d   = wdata[int'(pickId)*DW +: DW];
               end else begin
                  rfsel_d = '0;
                  re_d    = 1'b0;
                  we_d    = 1'b0;
               end
            end
         end
         DRIVE: begin
            rfsel_d    = '0;
            re_d       = 1'b0;
            we_d       = 1'b0;
            ack_d[id_q] = 1'b1;
            state_d    = ACK;
            if (sel_q < SW'(NUM_REGS)) begin
               err_d   = 1'b0;
               rdata_d = wr_q ? wdata_q : rf_p;
            end else begin
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ACK: begin
            err_d   = 1'b0;
            busy_d  = 1'b0;
            ptr_d   = (id_q == PW'(NREQ-1)) ? '0 : id_q + PW'(1);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         wr_q    <= 1'b0;
         sel_q   <= '0;
         wdata_q <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         rfd_q   <= '0;
         rfsel_q <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         wr_q    <= wr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         rfd_q   <= rfd_d;
         rfsel_q <= rfsel_d;
         re_q    <= re_d;
         we_q    <= we_d;
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign busy  = busy_q;
   assign rf_d  = rfd_q;
   assign rf_as = rfsel_q[REG_A];
   assign rf_bs = rfsel_q[REG_B];
   assign rf_cs = rfsel_q[REG_C];
   assign rf_ds = rfsel_q[REG_D];
   assign rf_fs = rfsel_q[REG_F];
   assign rf_re = re_q;
   assign rf_we = we_q;

endmodule

// File: doc/rf_arb.md
Name: rf_arb

Overview:
- Round-robin arbiter and sequencer that shares the 8-bit register file (registers A, B, C, D, F) between NREQ requesters.
- Each requester posts a single read or write. The block grants one requester at a time and drives the register file's one-hot selects (as/bs/cs/ds/fs), re, we and d.
- Read data is captured from the register file's p output. The requester receives a one-cycle ack with the data.
- Sits between the CPU-side masters (fetch/decode, DMA, debug) and the register file.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- DW, 8, data width; must match the register file.
- SW, 3, register-index width per requester.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester access request; level, held until ack.
- wr  in  NREQ  per-requester direction; 1 = write, 0 = read.
- sel  in  NREQ*SW  per-requester register index, packed; requester i uses bits [i*SW +: SW].
- wdata  in  NREQ*DW  per-requester write data, packed.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack; 1 = invalid register index, no access performed.
- rdata  out  DW  read result, valid during the ack cycle.
- busy  out  1  high while in DRIVE or ACK.
- rf_d  out  DW  to register file d.
- rf_as, rf_bs, rf_cs, rf_ds, rf_fs  out  1 each  one-hot register selects.
- rf_re  out  1  register file read enable.
- rf_we  out  1  register file write enable.
- rf_p  in  DW  register file read data p.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; round-robin pointer goes to 0.
  - ack, err, busy, rf_re, rf_we and all selects are 0.
  - rf_d and rdata are 0.
  - All outputs are registered and clear immediately, without waiting for a clock edge.
- Register index map: 0=A, 1=B, 2=C, 3=D, 4=F. Indices 5..7 are invalid.
- State machine, 3 states, one access per 3 cycles:
  - IDLE:
    - If any req is set, select the winner: the first set req bit at or after the pointer, searching upward with wrap-around.
    - Latch the winner's id, wr, sel and wdata, then go to DRIVE.
    - If no req is set, stay in IDLE.
  - DRIVE (busy=1):
    - Valid index: assert the matching one-hot select and rf_re=1; rf_we=latched wr; rf_d=latched wdata.
    - The register file performs the write on the rising edge ending this cycle.
    - For a read, capture rf_p into rdata on that same edge.
    - Invalid index: no select asserted, rf_re=rf_we=0, err latched as 1.
    - Go to ACK.
  - ACK (busy=1):
    - Deassert all selects, rf_re and rf_we.
    - ack[id]=1 for this one cycle; err and rdata are valid.
    - For a write, rdata holds the written value.
    - Pointer becomes (id+1) mod NREQ. Go to IDLE.
- Latency: req seen in IDLE at cycle 0 → rf access in cycle 1 → ack in cycle 2. A requester that keeps req high after ack is re-arbitrated in the next IDLE cycle.
- Requester rules:
  - req, wr, sel and wdata must be held stable until ack.
  - Changes after the IDLE latch have no effect.
  - Dropping req after the latch does not abort the access; ack still pulses.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ accesses.
- Simultaneous events:
  - Only one grant is issued per arbitration.
  - A request arriving during DRIVE or ACK is considered at the next IDLE.
- Reset mid-operation:
  - If reset is asserted during DRIVE, rf_we drops asynchronously before any clock edge, so the write is dropped.
  - No ack is issued for the aborted access.
- Selects are always one-hot or all-zero. rf_we=1 never occurs without exactly one select asserted.

Decomposition:
- Shared package (rf_pkg) holds:
  - the register-index constants REG_A..REG_F and the count of valid registers (5);
  - the data width (8);
  - the state encoding IDLE/DRIVE/ACK.
- One sub-module: rr_pick. It is combinational and takes (req vector, pointer) to produce (valid, winner id). It is reusable by other arbiters.
- The select decoder stays inline.

Test Plan:
- Single write: requester 0 writes 100 to A → in cycle 1 rf_as=1, rf_we=1, rf_d=100; in cycle 2 ack[0]=1, err=0.
- Read-back: requester 1 reads A after the previous write → rf_re=1 and rf_as=1 in cycle 1; in cycle 2 ack[1]=1, rdata=100.
- Fairness: all 4 requesters write indices 0..3 simultaneously and hold req → acks appear in order 0,1,2,3,0, spaced 3 cycles apart. Reading back D returns requester 3's data.
- Invalid index: requester 2 writes with sel=6, wdata=54 → no select and rf_we=0 in DRIVE; ack[2]=1 with err=1; register file unchanged.
- Reset mid-write:
  - Requester 0 writes 30 to B; rst drops during DRIVE.
  - Required: rf_we and rf_bs go to 0 asynchronously, no ack, state is IDLE after release.
  - A subsequent read of B returns the old value.
- Pointer wrap: pointer=3 with req=4'b0101 → requester 0 is granted, then requester 2.
